// File: rtl/sprite_overlay_pkg.sv
// Shared definitions for the moon sprite overlay: bitmap, motion states, RGB9 helpers.
package sprite_overlay_pkg;

    localparam int VIS_W    = 640;
    localparam int VIS_H    = 480;
    localparam int SPR_SIZE = 16;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } motion_state_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb9_t;

    // Moon bitmap: row 0 is the top row, bit 15 is the leftmost pixel.
    // Row 15 carries a lone "star" pixel at the far right.
    function automatic logic [15:0] sprite_row(input logic [3:0] idx);
        case (idx)
            4'd0:    sprite_row = 16'h07E0;
            4'd1:    sprite_row = 16'h1F80;
            4'd2:    sprite_row = 16'h3E00;
            4'd3:    sprite_row = 16'h7C00;
            4'd4:    sprite_row = 16'h7800;
            4'd5:    sprite_row = 16'hF800;
            4'd6:    sprite_row = 16'hF000;
            4'd7:    sprite_row = 16'hF000;
            4'd8:    sprite_row = 16'hF000;
            4'd9:    sprite_row = 16'hF000;
            4'd10:   sprite_row = 16'hF800;
            4'd11:   sprite_row = 16'h7800;
            4'd12:   sprite_row = 16'h7C00;
            4'd13:   sprite_row = 16'h3E00;
            4'd14:   sprite_row = 16'h1F80;
            default: sprite_row = 16'h07E1;
        endcase
    endfunction

    function automatic rgb9_t rgb9_pack(input logic [2:0] r, input logic [2:0] g,
                                        input logic [2:0] b);
        rgb9_pack = {r, g, b};
    endfunction

    // Half-intensity version of a colour, each channel shifted right by one.
    function automatic rgb9_t rgb9_half(input rgb9_t c);
        rgb9_half = {1'b0, c.r[2:1], 1'b0, c.g[2:1], 1'b0, c.b[2:1]};
    endfunction

endpackage

// File: rtl/sprite_overlay_motion.sv
// Frame-rate motion controller for the moon sprite: start delay, freeze/hold,
// and per-axis bounce with clamping at the visible-area edges.
module sprite_motion
    import sprite_overlay_pkg::*;
#(
    parameter int DX          = 2,
    parameter int DY          = 1,
    parameter int X_MAX       = VIS_W - SPR_SIZE,
    parameter int Y_MAX       = VIS_H - SPR_SIZE,
    parameter int START_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       freeze,
    output logic [9:0] sx,
    output logic [9:0] sy
);

    localparam logic [9:0] C_DX    = 10'(DX);
    localparam logic [9:0] C_DY    = 10'(DY);
    localparam logic [9:0] C_XMAX  = 10'(X_MAX);
    localparam logic [9:0] C_YMAX  = 10'(Y_MAX);
    localparam logic [7:0] C_LAST  = 8'(START_DELAY - 1);

    motion_state_t r_state;
    logic [7:0]    r_frame_cnt;
    logic [9:0]    r_sx;
    logic [9:0]    r_sy;
    logic          r_dir_x_neg;
    logic          r_dir_y_neg;
    logic [10:0]   w_x_next;
    logic [10:0]   w_y_next;

    // One axis step: returns {new_dir_neg, new_pos}. Clamps to the edge and
    // reverses instead of overshooting; the forward sum is taken in 11 bits.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir_neg,
                                              input logic [9:0] step, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        if (!dir_neg) begin
            if (sum >= {1'b0, lim}) axis_step = {1'b1, lim};
            else                    axis_step = {1'b0, sum[9:0]};
        end else begin
            if (pos <= step)        axis_step = {1'b0, 10'd0};
            else                    axis_step = {1'b1, pos - step};
        end
    endfunction

    assign w_x_next = axis_step(r_sx, r_dir_x_neg, C_DX, C_XMAX);
    assign w_y_next = axis_step(r_sy, r_dir_y_neg, C_DY, C_YMAX);

    // Motion FSM: only frame_tick advances state or position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= WAIT;
            r_frame_cnt <= 8'd0;
            r_sx        <= 10'd0;
            r_sy        <= 10'd0;
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
        end else if (frame_tick) begin
            case (r_state)
                WAIT: begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    if (r_frame_cnt == C_LAST) r_state <= RUN;
                end
                RUN: begin
                    if (freeze) begin
                        r_state <= HOLD;
                    end else begin
                        {r_dir_x_neg, r_sx} <= w_x_next;
                        {r_dir_y_neg, r_sy} <= w_y_next;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        r_state             <= RUN;
                        {r_dir_x_neg, r_sx} <= w_x_next;
                        {r_dir_y_neg, r_sy} <= w_y_next;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

    assign sx = r_sx;
    assign sy = r_sy;

endmodule

// File: rtl/sprite_overlay.sv
// Overlays a bouncing 16x16 monochrome moon onto the 3-bit-per-channel pixel
// stream, one cycle of latency. Optional drop shadow: define
// SPRITE_OVERLAY_SHADOW_EN to darken background pixels offset (+2,+2) from set
// sprite bits.
module sprite_overlay
    import sprite_overlay_pkg::*;
#(
    parameter int         DX          = 2,
    parameter int         DY          = 1,
    parameter int         X_MAX       = VIS_W - SPR_SIZE,
    parameter int         Y_MAX       = VIS_H - SPR_SIZE,
    parameter int         START_DELAY = 4,
    parameter logic [8:0] SPR_RGB     = 9'o775
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic [2:0] rin,
    input  logic [2:0] gin,
    input  logic [2:0] bin,
    output logic [2:0] rout,
    output logic [2:0] gout,
    output logic [2:0] bout,
    output logic       out_valid
);

    logic [9:0]  w_sx;
    logic [9:0]  w_sy;
    logic [9:0]  w_ox;
    logic [9:0]  w_oy;
    logic        w_in_spr;
    logic [15:0] w_row;
    logic        w_spr_bit;
    logic        w_shadow_bit;
    rgb9_t       w_bg;
    rgb9_t       w_pix;
    rgb9_t       r_out;
    logic        r_valid;

    sprite_motion #(
        .DX          (DX),
        .DY          (DY),
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .START_DELAY (START_DELAY)
    ) u_motion (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .freeze     (freeze),
        .sx         (w_sx),
        .sy         (w_sy)
    );

    // Offsets wrap in 10 bits, so pixels left/above the sprite land far outside.
    assign w_ox      = px - w_sx;
    assign w_oy      = py - w_sy;
    assign w_in_spr  = (w_ox[9:4] == '0) && (w_oy[9:4] == '0);
    assign w_row     = sprite_row(w_oy[3:0]);
    // Bit 15 is the leftmost column, so column c maps to bit 15-c == ~c.
    assign w_spr_bit = w_in_spr & w_row[~w_ox[3:0]];
    assign w_bg      = rgb9_pack(rin, gin, bin);

`ifdef SPRITE_OVERLAY_SHADOW_EN
    logic [9:0]  w_sh_ox;
    logic [9:0]  w_sh_oy;
    logic [15:0] w_sh_row;

    assign w_sh_ox      = w_ox - 10'd2;
    assign w_sh_oy      = w_oy - 10'd2;
    assign w_sh_row     = sprite_row(w_sh_oy[3:0]);
    assign w_shadow_bit = (w_sh_ox[9:4] == '0) && (w_sh_oy[9:4] == '0) &&
                          w_sh_row[~w_sh_ox[3:0]];
`else
    assign w_shadow_bit = 1'b0;
`endif

    // Colour select: sprite beats its own shadow, shadow beats background.
    always_comb begin
        w_pix = w_bg;
        if (w_spr_bit)         w_pix = rgb9_t'(SPR_RGB);
        else if (w_shadow_bit) w_pix = rgb9_half(w_bg);
    end

    // Output register: blanked whenever the input pixel is not visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= pix_valid;
            r_out   <= pix_valid ? w_pix : '0;
        end
    end

    assign rout      = r_out.r;
    assign gout      = r_out.g;
    assign bout      = r_out.b;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_sprite_overlay.sv
// Randomized self-checking bench for sprite_overlay against a behavioural model.
module tb_sprite_overlay;

    localparam int         DX          = 2;
    localparam int         DY          = 1;
    localparam int         X_MAX       = 624;
    localparam int         Y_MAX       = 464;
    localparam int         START_DELAY = 4;
    localparam logic [8:0] SPR         = 9'o775;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic [9:0] px;
    logic [9:0] py;
    logic       frame_tick;
    logic       freeze;
    logic [2:0] rin, gin, bin;
    logic [2:0] rout, gout, bout;
    logic       out_valid;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    // Model state: sprite position, direction, and ticks seen since reset.
    int         m_x, m_y, m_ticks;
    bit         m_xneg, m_yneg;
    logic       exp_valid;
    logic [8:0] exp_rgb;

    string moon [16] = '{
        ".....######.....",
        "...######.......",
        "..#####.........",
        ".#####..........",
        ".####...........",
        "#####...........",
        "####............",
        "####............",
        "####............",
        "####............",
        "#####...........",
        ".####...........",
        ".#####..........",
        "..#####.........",
        "...######.......",
        ".....######....#"
    };

    sprite_overlay #(
        .DX(DX), .DY(DY), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .START_DELAY(START_DELAY), .SPR_RGB(SPR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .px(px), .py(py),
        .frame_tick(frame_tick), .freeze(freeze),
        .rin(rin), .gin(gin), .bin(bin),
        .rout(rout), .gout(gout), .bout(bout), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic bit moon_bit(input int dx, input int dy);
        if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return 1'b0;
        return moon[dy].getc(dx) == 8'h23;
    endfunction

    function automatic logic [8:0] expect_pixel(input int x, input int y, input logic [8:0] bg);
        int dx, dy;
        dx = x - m_x;
        dy = y - m_y;
        if (moon_bit(dx, dy)) return SPR;
`ifdef SPRITE_OVERLAY_SHADOW_EN
        if (moon_bit(dx - 2, dy - 2))
            return {1'b0, bg[8:7], 1'b0, bg[5:4], 1'b0, bg[2:1]};
`endif
        return bg;
    endfunction

    function automatic void axis(input int p, input bit neg, input int step, input int lim,
                                 output int np, output bit nneg);
        np = p; nneg = neg;
        if (!neg) begin
            if (p + step >= lim) begin np = lim; nneg = 1'b1; end
            else np = p + step;
        end else begin
            if (p <= step) begin np = 0; nneg = 1'b0; end
            else np = p - step;
        end
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %o, expected %o", name, act, exp);
    endtask

    // Reference model: registers what the outputs must be after this edge.
    always @(posedge clk) begin
        int nx, ny;
        bit nxn, nyn;
        if (!rst_n) begin
            m_x <= 0; m_y <= 0; m_xneg <= 1'b0; m_yneg <= 1'b0; m_ticks <= 0;
            exp_valid <= 1'b0; exp_rgb <= 9'd0;
        end else begin
            exp_valid <= pix_valid;
            exp_rgb   <= pix_valid ? expect_pixel(int'(px), int'(py), {rin, gin, bin}) : 9'd0;
            if (frame_tick) begin
                if (m_ticks < START_DELAY) begin
                    m_ticks <= m_ticks + 1;
                end else if (!freeze) begin
                    axis(m_x, m_xneg, DX, X_MAX, nx, nxn);
                    axis(m_y, m_yneg, DY, Y_MAX, ny, nyn);
                    m_x <= nx; m_xneg <= nxn;
                    m_y <= ny; m_yneg <= nyn;
                end
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("out_valid", {8'd0, out_valid}, {8'd0, exp_valid});
            check("rgb", {rout, gout, bout}, exp_rgb);
        end
    end

    task automatic drive(input bit v, input int x, input int y, input bit tick,
                         input bit frz, input logic [8:0] bg);
        pix_valid  = v;
        px         = 10'(x);
        py         = 10'(y);
        frame_tick = tick;
        freeze     = frz;
        {rin, gin, bin} = bg;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [8:0] exp);
        check(name, {rout, gout, bout}, exp);
    endtask

    initial begin
        int x, y;
        rst_n = 1'b0;
        pix_valid = 1'b0; px = '0; py = '0; frame_tick = 1'b0; freeze = 1'b0;
        rin = '0; gin = '0; bin = '0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        drive(1, 5, 0, 0, 0, 9'o777);
        lit("reset_rgb", 9'o000);
        drive(1, 5, 0, 1, 0, 9'o777);
        rst_n = 1'b1;

        // Sprite at the origin right after reset.
        drive(1, 0, 0, 0, 0, 9'o123);
        lit("origin_bg", 9'o123);
        drive(1, 5, 0, 0, 0, 9'o123);
        lit("origin_spr", SPR);
        drive(0, 5, 0, 0, 0, 9'o123);
        lit("invalid_zero", 9'o000);

        // Start delay, with freeze held (must be ignored while waiting).
        for (int i = 0; i < START_DELAY; i++) drive(0, 0, 0, 1, 1, 9'o0);
        drive(1, 5, 0, 0, 0, 9'o444);
        lit("wait_no_move", SPR);
        drive(1, 5, 0, 1, 0, 9'o444);
        lit("tick_uses_old_pos", SPR);
        drive(1, 7, 1, 0, 0, 9'o444);
        lit("moved_spr", SPR);
        drive(1, 5, 0, 0, 0, 9'o444);
        lit("moved_old_spot", 9'o444);
        drive(1, 6, 1, 0, 0, 9'o444);
        lit("moved_row0_gap", 9'o444);

        // Freeze in RUN, then release.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 9'o0);
        drive(1, 7, 1, 0, 1, 9'o252);
        lit("frozen_spr", SPR);
        drive(0, 0, 0, 1, 0, 9'o0);
        drive(1, 9, 2, 0, 0, 9'o252);
        lit("unfrozen_spr", SPR);
        drive(1, 7, 1, 0, 0, 9'o252);
        lit("unfrozen_old", 9'o252);

`ifdef SPRITE_OVERLAY_SHADOW_EN
        // Sprite now at (4,2); shadow of row15 star pixel lands at (4+17, 2+17).
        drive(1, 21, 19, 0, 0, 9'o666);
        lit("shadow_hit", 9'o333);
        drive(1, 20, 18, 0, 0, 9'o666);
        lit("shadow_miss", 9'o666);
`endif

        // Full visible line through the sprite, with occasional blanking.
        for (int i = 0; i < 640; i++)
            drive(($urandom_range(0, 7) != 0), i, 7, 0, 0, 9'($urandom));

        // Random frames with pixels concentrated around the sprite.
        for (int f = 0; f < 1200; f++) begin
            for (int k = 0; k < 12; k++) begin
                x = m_x - 3 + $urandom_range(0, 21);
                y = m_y - 3 + $urandom_range(0, 21);
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                drive(($urandom_range(0, 7) != 0), x, y, 0, 0, 9'($urandom));
            end
            drive($urandom_range(0, 1), m_x + 5, m_y, 1, ($urandom_range(0, 4) == 0),
                  9'($urandom));
        end

        // Reset mid-run returns the sprite to the origin.
        rst_n = 1'b0;
        drive(1, 5, 0, 0, 0, 9'o111);
        drive(1, 5, 0, 0, 0, 9'o111);
        rst_n = 1'b1;
        drive(1, 5, 0, 0, 0, 9'o111);
        lit("rereset_spr", SPR);
        drive(0, 0, 0, 0, 0, 9'o0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
